// File: rtl/sequence_generator.sv
// sequence_generator: sends a latched four-digit code on the number bus,
// one nibble per clock. The code can be repeated with idle gaps between
// frames, and the block reports busy/done.
module sequence_generator #(
    parameter logic [3:0] IDLE_NIBBLE = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] code,
    input  logic [3:0]  repeats,
    input  logic [3:0]  gap,
    output logic [3:0]  number,
    output logic        frame,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]  state_q,       state_d;
    logic [15:0] code_q,        code_d;
    logic [3:0]  frames_left_q, frames_left_d;
    logic [3:0]  gap_q,         gap_d;
    logic [3:0]  gap_cnt_q,     gap_cnt_d;
    logic [1:0]  idx_q,         idx_d;
    logic [3:0]  number_d;
    logic        frame_d;
    logic        busy_d;
    logic        done_d;

    // Picks digit i of a code; digit 0 is the most significant nibble.
    function automatic logic [3:0] digit(input logic [15:0] c, input logic [1:0] i);
        logic [3:0] d;
        case (i)
            2'd0:    d = c[15:12];
            2'd1:    d = c[11:8];
            2'd2:    d = c[7:4];
            default: d = c[3:0];
        endcase
        return d;
    endfunction

    // State, latched parameters, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            code_q        <= 16'h0000;
            frames_left_q <= 4'h0;
            gap_q         <= 4'h0;
            gap_cnt_q     <= 4'h0;
            idx_q         <= 2'd0;
            number        <= IDLE_NIBBLE;
            frame         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            frames_left_q <= frames_left_d;
            gap_q         <= gap_d;
            gap_cnt_q     <= gap_cnt_d;
            idx_q         <= idx_d;
            number        <= number_d;
            frame         <= frame_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

    // Next-state and next-output decode; filler outputs are the default.
    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        frames_left_d = frames_left_q;
        gap_d         = gap_q;
        gap_cnt_d     = gap_cnt_q;
        idx_d         = idx_q;
        number_d      = IDLE_NIBBLE;
        frame_d       = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_SEND;
                    code_d        = code;
                    frames_left_d = repeats;
                    gap_d         = gap;
                    idx_d         = 2'd0;
                    number_d      = code[15:12];
                    frame_d       = 1'b1;
                    busy_d        = 1'b1;
                end
            end

            S_SEND: begin
                if (idx_q != 2'd3) begin
                    idx_d    = idx_q + 2'd1;
                    number_d = digit(code_q, idx_q + 2'd1);
                    frame_d  = 1'b1;
                    busy_d   = 1'b1;
                end else if (frames_left_q != 4'h0) begin
                    frames_left_d = frames_left_q - 4'h1;
                    idx_d         = 2'd0;
                    busy_d        = 1'b1;
                    if (gap_q == 4'h0) begin
                        // Back-to-back frame: restart the digit sequence now.
                        number_d = code_q[15:12];
                        frame_d  = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_q;
                    end
                end else begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    done_d  = 1'b1;
                end
            end

            S_GAP: begin
                busy_d    = 1'b1;
                gap_cnt_d = gap_cnt_q - 4'h1;
                // Last filler cycle: the next cycle carries the first digit.
                if (gap_cnt_q == 4'h1) begin
                    state_d  = S_SEND;
                    idx_d    = 2'd0;
                    number_d = code_q[15:12];
                    frame_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Transmit-side counterpart to the team's 4-bit digit-sequence detector. On a start request, the block drives a programmable four-digit code onto a 4-bit `number` bus, one digit per clock. It can repeat the code a programmable number of times with programmable idle gaps between frames, and reports busy/done status. It is the stimulus source and loopback partner for the detector: its `number` output connects directly to the detector's `number` input on the same clock.

## Interface
- `IDLE_NIBBLE`, default 4'hF: value driven on `number` whenever no code digit is being sent.
- `clock`  input  1  single system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request to send; sampled only in IDLE.
- `code`  input  16  four digits, sent MSB nibble first; latched when `start` is accepted.
- `repeats`  input  4  extra frame count; frames sent = `repeats` + 1 (range 1..16); latched on accept.
- `gap`  input  4  idle cycles between consecutive frames (0..15); latched on accept.
- `number`  output  4  digit bus (registered).
- `frame`  output  1  high exactly in the cycles where `number` carries a code digit.
- `busy`  output  1  high from the first digit cycle through the last digit cycle.
- `done`  output  1  one-cycle pulse in the cycle after the last digit of the last frame.

## Operation
- States:
  - IDLE: waiting for `start`.
  - SEND: digit index `idx` runs 0..3.
  - GAP: gap counter running.
- Internal registers: `code_q`[15:0], `frames_left`[3:0], `gap_q`[3:0], `gap_cnt`[3:0], `idx`[1:0].
- IDLE → SEND when `start`=1.
  - Latch `code`, `repeats` → `frames_left`, and `gap`.
  - Set `idx`=0 and register `number`=`code[15:12]`, `frame`=1, `busy`=1.
- SEND, `idx`<3: increment `idx` and drive the next nibble. Digit order is [15:12], [11:8], [7:4], [3:0].
- SEND, `idx`=3 (last digit of a frame), with `frames_left`>0:
  - Decrement `frames_left`.
  - If `gap_q`=0: go straight to SEND with `idx`=0 and drive `code_q[15:12]`. Frames are back-to-back with no filler.
  - If `gap_q`>0: go to GAP, load `gap_cnt`=`gap_q`, and drive `IDLE_NIBBLE` with `frame`=0, `busy`=1.
- SEND, `idx`=3, with `frames_left`=0:
  - Go to IDLE.
  - Register `number`=`IDLE_NIBBLE`, `frame`=0, `busy`=0, `done`=1.
- GAP: decrement `gap_cnt` each cycle. The cycle in which `gap_cnt`=1 transitions to SEND with `idx`=0 and drives the first digit. Exactly `gap_q` filler cycles appear between frames.
- `done` is cleared on every cycle other than the one listed above.
- `start` outside IDLE is ignored: it is not queued and does not change the latched values.
- `code`, `repeats` and `gap` may change freely after the accept cycle without effect.
- Reset has priority over everything, including in mid-frame or mid-gap. The block returns to IDLE with the reset outputs, the partial frame is abandoned, and no `done` pulse is produced.

## Timing
- Reset values: `number`=`IDLE_NIBBLE`, `frame`=0, `busy`=0, `done`=0, state IDLE, and all internal counters 0.
- All outputs are registered; there is no combinational path from input to output.
- Start latency: if `start` is sampled at edge t, the first digit is valid in the cycle after edge t.
- Burst length: N = `repeats`+1 frames and G = `gap` occupy 4N + G(N−1) cycles, all with `busy`=1.
- `done` is high in the cycle after the last digit. `busy` is already 0 in that cycle, so a new `start` asserted during the `done` cycle is accepted. The next burst's first digit then follows immediately after the `done` cycle.
- Minimum spacing between bursts is one filler cycle (the `done` cycle).
- With `IDLE_NIBBLE` not equal to `code[15:12]`, the detector can only match on true frame boundaries.

## Test plan
- Single frame: reset, then `code`=16'h1094, `repeats`=0, `gap`=0, pulse `start`.
  - Required: `number` = 1,0,9,4 on 4 consecutive cycles with `frame`=1 and `busy`=1, then F with `done`=1 for one cycle.
  - In loopback, the detector `pattern` pulses once.
- Repeats with gap: `code`=16'h1094, `repeats`=2, `gap`=3.
  - Required: 1094 FFF 1094 FFF 1094, a total of 18 busy cycles, then a single `done`.
  - Detector pulses 3 times.
- Back-to-back frames: `repeats`=1, `gap`=0, `code`=16'hA5C3.
  - Required: A,5,C,3,A,5,C,3 contiguous with `frame` high for all 8 cycles, and `done` in cycle 9.
- Start while busy: pulse `start` with a different `code` during digit 2.
  - Required: the original sequence completes unchanged and no second burst occurs.
- Start on the `done` cycle: the first digit of the new burst appears in the next cycle, with no extra idle cycle.
- Reset mid-gap: assert `reset` during GAP of a `repeats`=3 burst.
  - Required: the next cycle shows `number`=F and `frame`, `busy`, `done` all 0.
  - No `done` pulse occurs afterwards.
  - A subsequent `start` behaves normally.
